// File: rtl/mor1kx_operand_fwd_cappuccino_pkg.sv
// mor1kx_operand_fwd_cappuccino_pkg: shared widths and load-use FSM encoding for operand forwarding
package mor1kx_operand_fwd_cappuccino_pkg;
   localparam int FWD_OW = 32;
   localparam int FWD_AW = 5;
   typedef enum logic {
      FWD_RUN       = 1'b0,
      FWD_WAIT_LOAD = 1'b1
   } fwd_state_e;
endpackage

// File: rtl/mor1kx_operand_fwd_cappuccino_fwd_port.sv
// mor1kx_operand_fwd_cappuccino_fwd_port: one operand's source tracking, ctrl match, hold register and mux
module mor1kx_operand_fwd_cappuccino_fwd_port
   import mor1kx_operand_fwd_cappuccino_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = FWD_OW,
   parameter int OPTION_RF_ADDR_WIDTH = FWD_AW
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            padv_decode_i,
   input  logic                            flush_i,
   input  logic                            hold_en_i,
   input  logic                            ctrl_wb_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] dec_adr_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] rf_i,
   output logic                            match_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] op_o
);
   logic [OPTION_RF_ADDR_WIDTH-1:0] adr_q;
   logic [OPTION_OPERAND_WIDTH-1:0] hold_q;
   logic                            hold_vld_q;
   assign match_o = ctrl_wb_i & (ctrl_rfd_i == adr_q) & (adr_q != '0);
   assign op_o    = hold_vld_q ? hold_q : match_o ? ctrl_result_i : rf_i;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         adr_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else if (flush_i) begin
         hold_vld_q <= 1'b0;
      end else if (padv_decode_i) begin
         adr_q      <= dec_adr_i;
         hold_vld_q <= 1'b0;
      end else if (hold_en_i & match_o) begin
         hold_q     <= ctrl_result_i;
         hold_vld_q <= 1'b1;
      end
endmodule

// File: rtl/mor1kx_operand_fwd_cappuccino.sv
// mor1kx_operand_fwd_cappuccino: ctrl-stage forwarding with load-use stall and operand hold
module mor1kx_operand_fwd_cappuccino
   import mor1kx_operand_fwd_cappuccino_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = FWD_OW,
   parameter int OPTION_RF_ADDR_WIDTH = FWD_AW
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            padv_decode_i,
   input  logic                            padv_execute_i,
   input  logic                            padv_ctrl_i,
   input  logic                            pipeline_flush_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfd_adr_i,
   input  logic                            execute_rf_wb_i,
   input  logic                            execute_op_load_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] rfa_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] rfb_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_i,
   input  logic                            ctrl_lsu_valid_i,
   output logic [OPTION_OPERAND_WIDTH-1:0] execute_opa_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] execute_opb_o,
   output logic                            fwd_stall_o
);
   fwd_state_e                      state_q, state_d;
   logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_q;
   logic                            ctrl_wb_q, ctrl_load_q;
   logic                            match_a, match_b, hold_en;
   // Hold only once the ctrl result is final: ALU results always, loads when the LSU delivers.
   assign hold_en = padv_ctrl_i & ~padv_execute_i & (~ctrl_load_q | ctrl_lsu_valid_i);
   mor1kx_operand_fwd_cappuccino_fwd_port #(
      .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH),
      .OPTION_RF_ADDR_WIDTH(OPTION_RF_ADDR_WIDTH)
   ) u_port_a (
      .clk(clk), .rst(rst), .padv_decode_i(padv_decode_i), .flush_i(pipeline_flush_i),
      .hold_en_i(hold_en), .ctrl_wb_i(ctrl_wb_q), .dec_adr_i(decode_rfa_adr_i),
      .ctrl_rfd_i(ctrl_rfd_q), .ctrl_result_i(ctrl_result_i), .rf_i(rfa_i),
      .match_o(match_a), .op_o(execute_opa_o)
   );
   mor1kx_operand_fwd_cappuccino_fwd_port #(
      .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH),
      .OPTION_RF_ADDR_WIDTH(OPTION_RF_ADDR_WIDTH)
   ) u_port_b (
      .clk(clk), .rst(rst), .padv_decode_i(padv_decode_i), .flush_i(pipeline_flush_i),
      .hold_en_i(hold_en), .ctrl_wb_i(ctrl_wb_q), .dec_adr_i(decode_rfb_adr_i),
      .ctrl_rfd_i(ctrl_rfd_q), .ctrl_result_i(ctrl_result_i), .rf_i(rfb_i),
      .match_o(match_b), .op_o(execute_opb_o)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= FWD_RUN;
         ctrl_rfd_q  <= '0;
         ctrl_wb_q   <= 1'b0;
         ctrl_load_q <= 1'b0;
      end else if (pipeline_flush_i) begin
         state_q   <= FWD_RUN;
         ctrl_wb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (padv_execute_i) begin
            ctrl_rfd_q  <= execute_rfd_adr_i;
            ctrl_wb_q   <= execute_rf_wb_i;
            ctrl_load_q <= execute_op_load_i;
         end else if (padv_ctrl_i) begin
            ctrl_wb_q <= 1'b0;
         end
      end
   always_comb begin
      fwd_stall_o = (state_q == FWD_WAIT_LOAD) ? ~ctrl_lsu_valid_i
                  : (match_a | match_b) & ctrl_load_q & ~ctrl_lsu_valid_i;
      state_d     = fwd_stall_o ? FWD_WAIT_LOAD : FWD_RUN;
   end
endmodule

// File: tb/tb_mor1kx_operand_fwd_cappuccino.sv
// tb_mor1kx_operand_fwd_cappuccino: directed scenarios plus random traffic against a pipeline-level model
module tb_mor1kx_operand_fwd_cappuccino;
   localparam int OW = 32;
   localparam int AW = 5;
   logic clk = 1'b0, rst = 1'b0;
   logic pd, pe, pc, fl, ewb, eld, lsu;
   logic [AW-1:0] da, db, ed;
   logic [OW-1:0] rfa, rfb, res, opa, opb;
   logic stall;
   int n_cmp = 0, n_err = 0;
   // Model: which sources the execute instr reads, what the ctrl instr produces, and pending held values.
   logic [AW-1:0] m_sa, m_sb, m_cd;
   bit m_cw, m_cl, m_hva, m_hvb, m_wait;
   logic [OW-1:0] m_ha, m_hb;
   mor1kx_operand_fwd_cappuccino dut (
      .clk(clk), .rst(rst), .padv_decode_i(pd), .padv_execute_i(pe), .padv_ctrl_i(pc),
      .pipeline_flush_i(fl), .decode_rfa_adr_i(da), .decode_rfb_adr_i(db),
      .execute_rfd_adr_i(ed), .execute_rf_wb_i(ewb), .execute_op_load_i(eld),
      .rfa_i(rfa), .rfb_i(rfb), .ctrl_result_i(res), .ctrl_lsu_valid_i(lsu),
      .execute_opa_o(opa), .execute_opb_o(opb), .fwd_stall_o(stall)
   );
   always #5 clk = ~clk;
   function automatic bit m_fwd(logic [AW-1:0] s);
      return m_cw && (m_cd == s) && (s != 0);
   endfunction
   function automatic logic [OW-1:0] m_op(bit hv, logic [OW-1:0] h, logic [AW-1:0] s, logic [OW-1:0] rf);
      if (hv) return h;
      return m_fwd(s) ? res : rf;
   endfunction
   function automatic bit m_stall();
      if (m_wait) return !lsu;
      return (m_fwd(m_sa) || m_fwd(m_sb)) && m_cl && !lsu;
   endfunction
   task automatic model_reset();
      m_sa = 0; m_sb = 0; m_cd = 0; m_cw = 0; m_cl = 0;
      m_hva = 0; m_hvb = 0; m_wait = 0; m_ha = 0; m_hb = 0;
   endtask
   task automatic model_step();
      bit fa, fb, st;
      fa = m_fwd(m_sa); fb = m_fwd(m_sb); st = m_stall();
      if (fl) begin
         m_cw = 0; m_hva = 0; m_hvb = 0; m_wait = 0;
      end else begin
         m_wait = st;
         if (pc && !pe && (!m_cl || lsu)) begin
            if (fa) begin m_ha = res; m_hva = 1; end
            if (fb) begin m_hb = res; m_hvb = 1; end
         end
         if (pd) begin m_sa = da; m_sb = db; m_hva = 0; m_hvb = 0; end
         if (pe) begin m_cd = ed; m_cw = ewb; m_cl = eld; end
         else if (pc) m_cw = 0;
      end
   endtask
   task automatic idle();
      pd = 0; pe = 0; pc = 0; fl = 0; ewb = 0; eld = 0; lsu = 0; da = 0; db = 0; ed = 0;
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask
   task automatic issue(logic [AW-1:0] dst, bit ld, logic [AW-1:0] sa, logic [AW-1:0] sb);
      idle(); pe = 1; ed = dst; ewb = 1; eld = ld; pd = 1; da = sa; db = sb;
      tick();
   endtask
   task automatic test_reset();
      idle(); rfa = 32'h0BAD_F00D; rfb = 32'h1357_9BDF; res = 32'hFFFF_FFFF;
      #1;
      n_cmp++; if (opa !== rfa) begin n_err++; $display("FAIL reset_opa got %h want %h", opa, rfa); end
      n_cmp++; if (opb !== rfb) begin n_err++; $display("FAIL reset_opb got %h want %h", opb, rfb); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
      @(negedge clk); rst = 1; model_reset();
   endtask
   task automatic test_alu_fwd();
      issue(5'd3, 0, 5'd3, 5'd0);
      idle(); res = 32'h1234; rfa = 32'hDEAD; rfb = 32'hBEEF;
      #1;
      n_cmp++; if (opa !== 32'h1234) begin n_err++; $display("FAIL alu_fwd_opa got %h want %h", opa, 32'h1234); end
      n_cmp++; if (opb !== 32'hBEEF) begin n_err++; $display("FAIL alu_fwd_opb got %h want %h", opb, 32'hBEEF); end
      tick();
   endtask
   task automatic test_r0();
      issue(5'd0, 0, 5'd0, 5'd0);
      idle(); res = 32'h55; rfa = 32'h0;
      #1;
      n_cmp++; if (opa !== 32'h0) begin n_err++; $display("FAIL r0_opa got %h want 0", opa); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got %b want 0", stall); end
      tick();
   endtask
   task automatic test_load_use();
      issue(5'd5, 1, 5'd0, 5'd5);
      for (int i = 0; i < 3; i++) begin
         idle(); res = $urandom; rfb = 32'h2222;
         #1;
         n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall%0d got %b want 1", i, stall); end
         tick();
      end
      idle(); lsu = 1; res = 32'hCAFE; pc = 1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_done_stall got %b want 0", stall); end
      n_cmp++; if (opb !== 32'hCAFE) begin n_err++; $display("FAIL load_done_opb got %h want %h", opb, 32'hCAFE); end
      tick();
      idle(); res = 32'h1111;
      #1;
      n_cmp++; if (opb !== 32'hCAFE) begin n_err++; $display("FAIL load_hold_opb got %h want %h", opb, 32'hCAFE); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_hold_stall got %b want 0", stall); end
      tick();
   endtask
   task automatic test_hold();
      issue(5'd7, 0, 5'd7, 5'd0);
      idle(); res = 32'h77; pc = 1; rfa = 32'hAAAA;
      #1;
      n_cmp++; if (opa !== 32'h77) begin n_err++; $display("FAIL hold_fwd got %h want %h", opa, 32'h77); end
      tick();
      idle(); res = 32'h99;
      #1;
      n_cmp++; if (opa !== 32'h77) begin n_err++; $display("FAIL hold_keep got %h want %h", opa, 32'h77); end
      tick();
      idle(); res = 32'h99; pd = 1; da = 5'd2;
      #1;
      n_cmp++; if (opa !== 32'h77) begin n_err++; $display("FAIL hold_until_decode got %h want %h", opa, 32'h77); end
      tick();
      idle();
      #1;
      n_cmp++; if (opa !== 32'hAAAA) begin n_err++; $display("FAIL hold_release got %h want %h", opa, 32'hAAAA); end
      tick();
   endtask
   task automatic test_flush_wait();
      issue(5'd4, 1, 5'd4, 5'd0);
      idle(); #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall got %b want 1", stall); end
      tick();
      idle(); #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_wait_stall got %b want 1", stall); end
      fl = 1;
      tick();
      idle(); #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall_drop got %b want 0", stall); end
      pd = 1; da = 5'd4;
      tick();
      idle(); res = 32'h4444; rfa = 32'h5555;
      #1;
      n_cmp++; if (opa !== 32'h5555) begin n_err++; $display("FAIL flush_no_fwd got %h want %h", opa, 32'h5555); end
      tick();
   endtask
   task automatic test_reset_in_wait();
      issue(5'd6, 1, 5'd6, 5'd6);
      idle(); res = 32'h6666; rfa = 32'h1A1A; rfb = 32'h2B2B;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rstw_pre_stall got %b want 1", stall); end
      tick();
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rstw_wait_stall got %b want 1", stall); end
      #1 rst = 0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstw_stall got %b want 0", stall); end
      n_cmp++; if (opa !== 32'h1A1A) begin n_err++; $display("FAIL rstw_opa got %h want %h", opa, 32'h1A1A); end
      n_cmp++; if (opb !== 32'h2B2B) begin n_err++; $display("FAIL rstw_opb got %h want %h", opb, 32'h2B2B); end
      model_reset();
      @(negedge clk); rst = 1;
   endtask
   task automatic test_random();
      logic [OW-1:0] ea, eb;
      bit es;
      for (int i = 0; i < 500; i++) begin
         pd = ($urandom_range(0, 2) == 0); pe = ($urandom_range(0, 2) == 0);
         pc = ($urandom_range(0, 1) == 0); fl = ($urandom_range(0, 19) == 0);
         da = AW'($urandom_range(0, 3)); db = AW'($urandom_range(0, 3)); ed = AW'($urandom_range(0, 3));
         ewb = 1'($urandom); eld = 1'($urandom); lsu = ($urandom_range(0, 2) == 0);
         rfa = $urandom; rfb = $urandom; res = $urandom;
         #1;
         ea = m_op(m_hva, m_ha, m_sa, rfa); eb = m_op(m_hvb, m_hb, m_sb, rfb); es = m_stall();
         n_cmp++; if (opa !== ea) begin n_err++; $display("FAIL rand%0d_opa got %h want %h", i, opa, ea); end
         n_cmp++; if (opb !== eb) begin n_err++; $display("FAIL rand%0d_opb got %h want %h", i, opb, eb); end
         n_cmp++; if (stall !== es) begin n_err++; $display("FAIL rand%0d_stall got %b want %b", i, stall, es); end
         tick();
      end
   endtask
   initial begin
      model_reset();
      idle(); rfa = 0; rfb = 0; res = 0;
      @(negedge clk);
      test_reset();
      test_alu_fwd();
      test_r0();
      test_load_use();
      test_hold();
      test_flush_wait();
      test_reset_in_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
